// File: rtl/ula_controle_mc_if.sv
// Control bundle between the multi-cycle main controller and the datapath/ALU.
// The controller connects as master: it reads the opcode, the function field and
// the ALU flag, and drives every control and debug line. The datapath side is slave.
interface ula_controle_mc_if;
    logic [3:0] Op;
    logic [2:0] Funct;
    logic       Zero;
    logic [2:0] ULAControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Zero,
        output ULAControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite,
               RegDst, MemtoReg, PCSrc, PCEn, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  ULAControl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite,
               RegDst, MemtoReg, PCSrc, PCEn, State
    );
endinterface

// File: rtl/ula_controle_mc.sv
// Multi-cycle main control unit for the 8-bit processor. A 4-bit Moore FSM
// sequences fetch/decode/execute/memory/writeback. Outputs are decoded from
// the state only, except PCEn (uses Zero) and ULAControl in EXEC (uses Funct).
module ula_controle_mc (
    input  logic              clk,
    input  logic              rst_n,
    ula_controle_mc_if.master bus
);

    typedef enum logic [3:0] {
        S0Fetch   = 4'd0,
        S1Decode  = 4'd1,
        S2MemAdr  = 4'd2,
        S3MemRd   = 4'd3,
        S4MemWb   = 4'd4,
        S5MemWr   = 4'd5,
        S6Exec    = 4'd6,
        S7AluWb   = 4'd7,
        S8Branch  = 4'd8,
        S9AddiEx  = 4'd9,
        S10AddiWb = 4'd10,
        S11Jump   = 4'd11
    } state_e;

    localparam logic [3:0] OpRType = 4'b0000;
    localparam logic [3:0] OpLw    = 4'b0001;
    localparam logic [3:0] OpSw    = 4'b0010;
    localparam logic [3:0] OpBeq   = 4'b0011;
    localparam logic [3:0] OpAddi  = 4'b0100;
    localparam logic [3:0] OpJ     = 4'b0101;

    state_e r_state;
    state_e w_state_next;
    state_e w_state_eff;

    logic [2:0] w_ula_control;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_branch;

    // State register; reset is sampled on the clock edge and wins mid-instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S0Fetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; Op is only looked at in DECODE and MEMADR.
    always_comb begin
        w_state_next = S0Fetch;
        case (r_state)
            S0Fetch: w_state_next = S1Decode;
            S1Decode: begin
                case (bus.Op)
                    OpRType:    w_state_next = S6Exec;
                    OpLw, OpSw: w_state_next = S2MemAdr;
                    OpBeq:      w_state_next = S8Branch;
                    OpAddi:     w_state_next = S9AddiEx;
                    OpJ:        w_state_next = S11Jump;
                    default:    w_state_next = S0Fetch;  // illegal op acts as a 2-cycle NOP
                endcase
            end
            S2MemAdr: begin
                if (bus.Op == OpLw) begin
                    w_state_next = S3MemRd;
                end else if (bus.Op == OpSw) begin
                    w_state_next = S5MemWr;
                end else begin
                    w_state_next = S0Fetch;
                end
            end
            S3MemRd:   w_state_next = S4MemWb;
            S6Exec:    w_state_next = S7AluWb;
            S9AddiEx:  w_state_next = S10AddiWb;
            default:   w_state_next = S0Fetch;  // S4/S5/S7/S8/S10/S11 and unused codes
        endcase
    end

    // While reset is low the outputs present FETCH decoding (State reads 0).
    assign w_state_eff = rst_n ? r_state : S0Fetch;

    // Moore output decode; anything not set for a state stays 0.
    always_comb begin
        w_ula_control = 3'b000;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_iord        = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_pc_src      = 2'b00;
        w_pc_write    = 1'b0;
        w_branch      = 1'b0;
        case (w_state_eff)
            S0Fetch: begin
                w_alu_src_b = 2'b01;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
            end
            S1Decode: begin
                w_alu_src_b = 2'b11;  // PC + branch offset parked in ALUOut
            end
            S2MemAdr, S9AddiEx: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S3MemRd: begin
                w_iord = 1'b1;
            end
            S4MemWb: begin
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S5MemWr: begin
                w_iord      = 1'b1;
                w_mem_write = 1'b1;
            end
            S6Exec: begin
                w_alu_src_a   = 1'b1;
                w_ula_control = bus.Funct;  // forwarded raw, 110/111 included
            end
            S7AluWb: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S8Branch: begin
                w_alu_src_a   = 1'b1;
                w_ula_control = 3'b001;
                w_pc_src      = 2'b01;
                w_branch      = 1'b1;
            end
            S10AddiWb: begin
                w_reg_write = 1'b1;
            end
            S11Jump: begin
                w_pc_src   = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.ULAControl = w_ula_control;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.IorD       = w_iord;
    assign bus.RegDst     = w_reg_dst;
    assign bus.MemtoReg   = w_mem_to_reg;
    assign bus.PCSrc      = w_pc_src;
    assign bus.State      = w_state_eff;

    // Write enables are suppressed combinationally so a reset cycle never writes.
    assign bus.IRWrite  = rst_n & w_ir_write;
    assign bus.MemWrite = rst_n & w_mem_write;
    assign bus.RegWrite = rst_n & w_reg_write;
    assign bus.PCEn     = rst_n & (w_pc_write | (w_branch & bus.Zero));

endmodule

// File: tb/tb_ula_controle_mc.sv
// Scoreboard bench for ula_controle_mc: the driver pushes the hand-derived
// output vector for each cycle, the monitor pops and compares at the falling edge.
module tb_ula_controle_mc;

    logic clk;
    logic rst_n;

    ula_controle_mc_if bus ();

    ula_controle_mc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk;
    int n_fail;
    logic [18:0] exp_q[$];
    string       tag_q[$];

    logic [18:0] w_act;
    assign w_act = {bus.State, bus.ULAControl, bus.ALUSrcA, bus.ALUSrcB, bus.IorD, bus.IRWrite,
                    bus.MemWrite, bus.RegWrite, bus.RegDst, bus.MemtoReg, bus.PCSrc, bus.PCEn};

    // Output table per state, written from the control specification.
    function automatic logic [18:0] exp_vec(input int st, input logic [2:0] f, input logic z,
                                            input logic rn);
        logic [3:0] s;
        logic [2:0] ul;
        logic       sa;
        logic [1:0] sb;
        logic       iord, irw, mw, rw, rd, m2r, pce;
        logic [1:0] pcs;
        ul = 3'b000; sa = 1'b0; sb = 2'b00; iord = 1'b0; irw = 1'b0; mw = 1'b0;
        rw = 1'b0; rd = 1'b0; m2r = 1'b0; pcs = 2'b00; pce = 1'b0;
        s = rn ? st[3:0] : 4'd0;
        case (s)
            4'd0:  begin sb = 2'b01; irw = 1'b1; pce = 1'b1; end
            4'd1:  begin sb = 2'b11; end
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin iord = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; end
            4'd5:  begin iord = 1'b1; mw = 1'b1; end
            4'd6:  begin sa = 1'b1; ul = f; end
            4'd7:  begin rd = 1'b1; rw = 1'b1; end
            4'd8:  begin sa = 1'b1; ul = 3'b001; pcs = 2'b01; pce = z; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; end
            4'd11: begin pcs = 2'b10; pce = 1'b1; end
            default: begin end
        endcase
        if (!rn) begin
            irw = 1'b0; pce = 1'b0; mw = 1'b0; rw = 1'b0;
        end
        return {s, ul, sa, sb, iord, irw, mw, rw, rd, m2r, pcs, pce};
    endfunction

    // Apply one cycle of inputs just after the rising edge and log the expectation.
    task automatic drive(input logic rn, input logic [3:0] op, input logic [2:0] f,
                         input logic z, input int st, input string tag);
        @(posedge clk);
        #1;
        rst_n     = rn;
        bus.Op    = op;
        bus.Funct = f;
        bus.Zero  = z;
        exp_q.push_back(exp_vec(st, f, z, rn));
        tag_q.push_back(tag);
    endtask

    // One instruction: seq lists the hand-derived state per cycle. zb is Zero in
    // BRANCH, zo is Zero elsewhere. rst_at >= 0 pulls reset low in that cycle.
    task automatic run_instr(input logic [3:0] op, input logic [2:0] f, input logic zb,
                             input logic zo, input int n, input int seq[6], input int rst_at,
                             input string tag);
        for (int i = 0; i < n; i++) begin
            int   s;
            logic z;
            s = seq[i];
            z = (s == 8) ? zb : zo;
            if (i == rst_at) begin
                drive(1'b0, op, f, z, s, {tag, "_rst"});
                return;
            end
            drive(1'b1, op, f, z, s, tag);
        end
    endtask

    // Monitor: compare whatever the DUT shows against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                logic [18:0] e;
                string       t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_chk++;
                if (w_act !== e) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %05h expected %05h (state got %0d exp %0d)",
                             t, $time, w_act, e, w_act[18:15], e[18:15]);
                end
            end
        end
    end

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.Op    = 4'b0000;
        bus.Funct = 3'b000;
        bus.Zero  = 1'b1;

        // Reset held for two edges; enables must stay low.
        drive(1'b0, 4'b0011, 3'b000, 1'b1, 0, "reset0");
        drive(1'b0, 4'b0011, 3'b000, 1'b1, 0, "reset1");

        // R-type for every Funct code, Zero toggled in non-branch states.
        for (int f = 0; f < 8; f++) begin
            run_instr(4'b0000, f[2:0], 1'b0, f[0], 4, '{0, 1, 6, 7, 0, 0}, -1, "rtype");
        end

        run_instr(4'b0001, 3'b000, 1'b0, 1'b1, 5, '{0, 1, 2, 3, 4, 0}, -1, "lw");
        run_instr(4'b0010, 3'b000, 1'b0, 1'b0, 4, '{0, 1, 2, 5, 0, 0}, -1, "sw");
        run_instr(4'b0011, 3'b000, 1'b1, 1'b0, 3, '{0, 1, 8, 0, 0, 0}, -1, "beq_taken");
        run_instr(4'b0011, 3'b111, 1'b0, 1'b1, 3, '{0, 1, 8, 0, 0, 0}, -1, "beq_not");
        run_instr(4'b0100, 3'b010, 1'b0, 1'b1, 4, '{0, 1, 9, 10, 0, 0}, -1, "addi");
        run_instr(4'b0101, 3'b000, 1'b0, 1'b0, 3, '{0, 1, 11, 0, 0, 0}, -1, "jump");
        run_instr(4'b1111, 3'b000, 1'b0, 1'b1, 2, '{0, 1, 0, 0, 0, 0}, -1, "illegal_f");
        run_instr(4'b0110, 3'b000, 1'b0, 1'b0, 2, '{0, 1, 0, 0, 0, 0}, -1, "illegal_6");

        // Reset mid-store and mid-load, then a clean store to confirm recovery.
        run_instr(4'b0010, 3'b000, 1'b0, 1'b1, 4, '{0, 1, 2, 5, 0, 0}, 3, "sw_midrst");
        run_instr(4'b0001, 3'b000, 1'b0, 1'b0, 5, '{0, 1, 2, 3, 4, 0}, 3, "lw_midrst");
        run_instr(4'b0010, 3'b000, 1'b0, 1'b0, 4, '{0, 1, 2, 5, 0, 0}, -1, "sw_after");
        run_instr(4'b0000, 3'b101, 1'b0, 1'b1, 4, '{0, 1, 6, 7, 0, 0}, -1, "rtype_slt");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_controle_mc.md
Name: ula_controle_mc

Overview:
- Multi-cycle main control unit for the 8-bit processor; it drives the ALU from the other end of its control interface.
- Each cycle it issues the 3-bit ALU op code, selects the ALU operands, and sequences fetch/decode/execute/memory/writeback through a Moore FSM.
- It consumes the ALU Zero flag to resolve branches.
- Sits between the instruction register / datapath muxes and the ALU, register file, PC and memory enables.

Parameters:
- none. The FSM and the instruction encoding are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Op  in  4  opcode field of the instruction register:
  - 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 ADDI, 0101 J
  - any other value is illegal
- Funct  in  3  R-type function field; forwarded as the ALU op
- Zero  in  1  ALU zero flag, combinational from the ALU in the same cycle
- ULAControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register load enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- RegDst  out  1  destination register select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = memory data
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable = PCWrite | (Branch & Zero)
- State  out  4  current state encoding, for debug

Behaviour:
- Registered 4-bit state; all outputs are decoded combinationally from state only. Exceptions: PCEn (also depends on Zero) and ULAControl in EXEC (also depends on Funct).
- Every output not listed for a state is 0.
- States and outputs:
  - S0 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ULAControl=000, PCSrc=00, IRWrite=1, PCWrite=1. Next state: S1.
  - S1 DECODE: ALUSrcA=0, ALUSrcB=11, ULAControl=000 (branch target into ALUOut). Next state by Op:
    - 0000 -> S6
    - 0001 or 0010 -> S2
    - 0011 -> S8
    - 0100 -> S9
    - 0101 -> S11
    - illegal -> S0 (the instruction is a 2-cycle NOP)
  - S2 MEMADR: ALUSrcA=1, ALUSrcB=10, ULAControl=000. Next state: LW -> S3, SW -> S5.
  - S3 MEMRD: IorD=1. Next state: S4.
  - S4 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state: S0.
  - S5 MEMWR: IorD=1, MemWrite=1. Next state: S0.
  - S6 EXEC: ALUSrcA=1, ALUSrcB=00, ULAControl=Funct, passed unmodified including 110/111. Next state: S7.
  - S7 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state: S0.
  - S8 BRANCH: ALUSrcA=1, ALUSrcB=00, ULAControl=001, PCSrc=01, Branch=1. Next state: S0.
  - S9 ADDIEX: ALUSrcA=1, ALUSrcB=10, ULAControl=000. Next state: S10.
  - S10 ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state: S0.
  - S11 JUMP: PCSrc=10, PCWrite=1. Next state: S0.
  - Unused encodings 12-15 -> S0 on the next edge, with all outputs 0.
- Op and Funct are sampled only in S1/S2/S6. The instruction register holds them stable after FETCH; the FSM does not latch them internally.
- Latency in cycles, FETCH through the last state:
  - R-type 4, LW 5, SW 4, BEQ 3, ADDI 4, J 3, illegal 2.
- PCEn in S8 equals Zero in that same cycle (taken iff A==B). PCEn is 1 in S0 and S11 and 0 elsewhere.
- Reset:
  - rst_n=0 at a rising edge -> state=S0 regardless of the current state, including mid-instruction (e.g. in S3 or S5); no partial write completes afterwards.
  - While rst_n=0, IRWrite, PCWrite, PCEn, MemWrite and RegWrite are forced to 0. All other outputs show their S0 values; State=0000.
- First FETCH occurs in the first cycle after rst_n returns to 1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges from arbitrary state -> State=0000, all enables 0. Release -> IRWrite=1, PCEn=1, ALUSrcB=01, ULAControl=000 in the next cycle.
- R-type sub: Op=0000, Funct=001 -> states 0,1,6,7,0. In S6, ULAControl=001, ALUSrcA=1, ALUSrcB=00. In S7, RegWrite=1, RegDst=1. Repeat for Funct 000..101 and check ULAControl matches Funct.
- LW then SW:
  - Op=0001 -> states 0,1,2,3,4; MemtoReg=1 and RegWrite=1 only in S4.
  - Op=0010 -> states 0,1,2,5; MemWrite=1 only in S5, IorD=1.
- BEQ: Op=0011 with Zero=1 in S8 -> PCEn=1, PCSrc=01. With Zero=0 -> PCEn=0. Zero=1 in S2 or S6 never asserts PCEn.
- ADDI and J:
  - Op=0100 -> states 0,1,9,10; ALUSrcB=10 in S9, RegDst=0 in S10.
  - Op=0101 -> states 0,1,11; PCSrc=10, PCEn=1 in S11.
  - Op=1111 -> states 0,1,0 with no write enables in S1.
- Mid-operation reset: rst_n=0 sampled while in S5 -> MemWrite=0 during that cycle, State=0000 next cycle, no further MemWrite pulse.
